iter_rotator: RTL
=================

# iter_rotator

Multi-cycle 8-bit barrel rotator with a valid/ready handshake on both sides. It rotates one bit position per clock and supports both right and left rotation. A left rotation is computed as bit-reverse, then rotate-right, then bit-reverse. The block is the sequential, area-lean counterpart to the combinational rotator path in the Multi_Barrel_Rotator design, for use where one rotation result per several cycles is acceptable.

## Interface
- WIDTH, 8, data width in bits; must be a power of two.
- AMT_W, $clog2(WIDTH) = 3, width of the rotate-amount field.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous assert, active-low; the only reset.
- start_valid  in  1  request present.
- start_ready  out  1  block can accept a request; high only in IDLE.
- din  in  WIDTH  operand; sampled on accept.
- amt  in  AMT_W  rotate amount, 0..WIDTH-1; sampled on accept.
- dir  in  1  0 = rotate right, 1 = rotate left; sampled on accept.
- dout  out  WIDTH  result; registered.
- out_valid  out  1  dout holds a valid result.
- out_ready  in  1  consumer accepts the result.

## Operation
- The state machine has three states: IDLE, ROTATE, DONE.
- Accept occurs when start_valid && start_ready.
- IDLE, on accept:
  - work <= dir ? reverse(din) : din.
  - cnt <= amt.
  - dir_q <= dir.
  - Go to DONE if amt == 0; otherwise go to ROTATE.
- IDLE without accept: hold state.
- ROTATE, each cycle:
  - work <= {work[0], work[WIDTH-1:1]}.
  - cnt <= cnt - 1.
  - When cnt == 1, this is the last shift; go to DONE.
- Entering DONE (from either IDLE or ROTATE):
  - dout <= dir_q ? reverse(work_next) : work_next, where work_next is the value work takes on that same edge.
  - out_valid <= 1.
- DONE: dout and out_valid hold. When out_ready is high, out_valid <= 0 and the machine goes to IDLE.
- start_ready is combinational: (state == IDLE). Requests presented outside IDLE are ignored and are not queued.
- dout changes only on entry to DONE. Between transactions it keeps the last result.
- Identity: reverse(rotr(reverse(x), k)) == rotl(x, k). No separate left-shift datapath exists.

## Timing
- Reset values:
  - state = IDLE.
  - dout = 0.
  - out_valid = 0.
  - work, cnt, dir_q = 0.
  - start_ready = 1, because it decodes IDLE.
- Latency from the accept edge to out_valid high is amt+1 cycles: 1 cycle for amt = 0, 8 cycles for amt = 7.
- Throughput: one result per amt+2 cycles at best. The extra cycle is the DONE→IDLE handshake; there is no back-to-back bypass.
- out_ready may be high before out_valid rises. Completion is then in the first DONE cycle, with out_valid high for exactly 1 cycle.
- Reset asserted mid-ROTATE or in DONE: all registers clear immediately (asynchronously). The in-flight result is discarded and no out_valid pulse is produced.
- start_valid held high through a whole transaction: exactly one accept per IDLE visit.

## Structure
- A shared package rot_pkg holds:
  - typedef enum state_t {IDLE, ROTATE, DONE}.
  - localparam ROT_WIDTH = 8.
  - localparam ROT_AMT_W = 3.
- One sub-module is natural: bit_reverse, a parameterized WIDTH-bit combinational reversal. It is instantiated twice, on the input load and the output capture.
- The FSM, counter, and shift register stay in iter_rotator. Estimated 150–250 lines of RTL total.

## Test plan
- Right rotate: din=8'hB1, amt=3, dir=0 → dout=8'h36, out_valid rises 4 cycles after accept.
- Left rotate: din=8'hB1, amt=3, dir=1 → dout=8'h8D, same 4-cycle latency.
- Zero amount: din=8'h5A, amt=0, dir=1 → dout=8'h5A after 1 cycle, with no ROTATE cycles.
- Maximum amount: din=8'h01, amt=7, dir=0 → dout=8'h02 after 8 cycles. Repeat with dir=1 → dout=8'h80.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing start_valid with din=8'hFF.
  - dout must stay stable and start_ready must stay 0.
  - After out_ready=1, the FSM returns to IDLE and the next accept uses the new operand.
- Reset mid-operation: assert rst_n=0 during the third ROTATE cycle of an amt=6 request.
  - dout=0, out_valid=0, and state IDLE immediately.
  - After release, din=8'hC3, amt=2, dir=0 → dout=8'hF0.

Source files
------------

// File: rtl/rot_pkg.sv
// Shared types and sizes for the iterative rotator.
package rot_pkg;

    localparam int unsigned ROT_WIDTH = 8;
    localparam int unsigned ROT_AMT_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage : rot_pkg

// File: rtl/bit_reverse.sv
// Combinational bit-order reversal: data_o[i] = data_i[WIDTH-1-i].
module bit_reverse #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    // Pure wiring swap, no logic.
    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign data_o[i] = data_i[WIDTH-1-i];
    end

endmodule : bit_reverse

// File: rtl/iter_rotator.sv
// Sequential rotator: one bit position per clock. Left rotation reuses the
// right-rotate shifter by reversing the operand on load and the result on capture.
module iter_rotator
    import rot_pkg::*;
#(
    parameter int unsigned WIDTH = ROT_WIDTH,
    parameter int unsigned AMT_W = ROT_AMT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] din,
    input  logic [AMT_W-1:0] amt,
    input  logic             dir,
    output logic [WIDTH-1:0] dout,
    output logic             out_valid,
    input  logic             out_ready
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [AMT_W-1:0]   cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               out_valid_q, out_valid_d;

    logic               accept;
    logic               load_en;
    logic               shift_en;
    logic               entering_done;
    logic [WIDTH-1:0]   din_rev;
    logic [WIDTH-1:0]   work_d_rev;

    // Reversal on the operand load path.
    bit_reverse #(.WIDTH(WIDTH)) u_rev_in (
        .data_i (din),
        .data_o (din_rev)
    );

    // Reversal on the result capture path; sees the value work takes this edge.
    bit_reverse #(.WIDTH(WIDTH)) u_rev_out (
        .data_i (work_d),
        .data_o (work_d_rev)
    );

    assign accept = start_valid && start_ready;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (amt == '0) ? DONE : ROTATE;
                end
            end
            ROTATE: begin
                if (cnt_q == AMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM output decode: handshake and datapath enables.
    always_comb begin
        start_ready   = 1'b0;
        load_en       = 1'b0;
        shift_en      = 1'b0;
        unique case (state_q)
            IDLE: begin
                start_ready = 1'b1;
                load_en     = start_valid;
            end
            ROTATE: begin
                shift_en = 1'b1;
            end
            default: begin
            end
        endcase
        entering_done = (state_d == DONE) && (state_q != DONE);
    end

    // Datapath next values: load, shift-right-by-one, and result capture.
    always_comb begin
        work_d      = work_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        dout_d      = dout_q;
        out_valid_d = out_valid_q;

        if (load_en) begin
            work_d = dir ? din_rev : din;
            cnt_d  = amt;
            dir_d  = dir;
        end else if (shift_en) begin
            work_d = {work_q[0], work_q[WIDTH-1:1]};
            cnt_d  = cnt_q - AMT_W'(1);
        end

        if (entering_done) begin
            dout_d      = dir_d ? work_d_rev : work_d;
            out_valid_d = 1'b1;
        end else if ((state_q == DONE) && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q      <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign dout      = dout_q;
    assign out_valid = out_valid_q;

endmodule : iter_rotator
